// File: rtl/game_round_controller_pkg.sv
// Shared types for the number-guessing game round controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK1  = 3'd2,
        CHECK2  = 3'd3,
        DECIDE  = 3'd4,
        DONE    = 3'd5
    } game_state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

endpackage

// File: rtl/game_round_controller_if.sv
// Bus between the player input stage, the game controller and the comparator.
// Handshake: a guess transfers on a rising Clock edge where Px_Valid and
// Px_Ready are both high; Px_Ready never depends on Px_Valid, and a Valid
// seen while Ready is low is simply not taken (no data is lost or queued).
// Cmp_Valid marks cycles where Cmp_Num/Cmp_Target are worth comparing;
// Cmp_Match is expected back combinationally in that same cycle.
// State is a read-only view of the controller FSM for checkers.
interface game_round_controller_if #(
    parameter int NUM_W   = 6,
    parameter int ROUND_W = 4
) ();
    logic                     Start;
    logic [NUM_W-1:0]         Target_Num;
    logic                     P1_Valid;
    logic [NUM_W-1:0]         P1_Num;
    logic                     P1_Ready;
    logic                     P2_Valid;
    logic [NUM_W-1:0]         P2_Num;
    logic                     P2_Ready;
    logic [NUM_W-1:0]         Cmp_Target;
    logic [NUM_W-1:0]         Cmp_Num;
    logic                     Cmp_Valid;
    logic                     Cmp_Match;
    logic [1:0]               Result;
    logic                     Done;
    logic [ROUND_W-1:0]       Round;
    game_pkg::game_state_e    State;

    modport master (
        output Start, Target_Num, P1_Valid, P1_Num, P2_Valid, P2_Num, Cmp_Match,
        input  P1_Ready, P2_Ready, Cmp_Target, Cmp_Num, Cmp_Valid,
               Result, Done, Round, State
    );

    modport slave (
        input  Start, Target_Num, P1_Valid, P1_Num, P2_Valid, P2_Num, Cmp_Match,
        output P1_Ready, P2_Ready, Cmp_Target, Cmp_Num, Cmp_Valid,
               Result, Done, Round, State
    );
endinterface

// File: rtl/game_round_controller_guess_slot.sv
// One player's guess slot: capture register, full flag, forfeit flag and Ready.
module guess_slot #(
    parameter int NUM_W = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             collect,
    input  logic             valid,
    input  logic [NUM_W-1:0] num,
    input  logic             forfeit_set,
    output logic             ready,
    output logic             full,
    output logic             forfeit,
    output logic [NUM_W-1:0] guess
);

    // Ready only while collecting into an empty, non-forfeited slot.
    assign ready = collect & ~full & ~forfeit;

    // Capture the guess on accept; clear wipes the slot for a new round.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            full    <= 1'b0;
            forfeit <= 1'b0;
            guess   <= '0;
        end else if (clear) begin
            full    <= 1'b0;
            forfeit <= 1'b0;
            guess   <= '0;
        end else begin
            if (valid && ready) begin
                full  <= 1'b1;
                guess <= num;
            end
            if (forfeit_set) forfeit <= 1'b1;
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the two-player guessing game sharing one comparator.
// Optional build macro GAME_TIMEOUT_EN adds a per-round collection timeout
// after which a silent player forfeits the round.
module game_round_controller
    import game_pkg::*;
#(
    parameter int NUM_W       = 6,
    parameter int MAX_ROUNDS  = 8,
    parameter int ROUND_W     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    game_round_controller_if.slave bus
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);

    game_state_e        state, next_state;
    logic [NUM_W-1:0]   target;
    logic [ROUND_W-1:0] round;
    logic [1:0]         result;
    logic               done;
    logic               m1, m2;

    logic               collect, timeout, start_acc, slot_clear;
    logic               p1_fill, p2_fill, p1_forfeit_set, p2_forfeit_set;
    logic               p1_full, p2_full, p1_forfeit, p2_forfeit;
    logic [NUM_W-1:0]   p1_guess, p2_guess, cmp_num;
    logic               cmp_valid;

    assign collect = (state == COLLECT);
    assign p1_fill = p1_full | (bus.P1_Valid & bus.P1_Ready);
    assign p2_fill = p2_full | (bus.P2_Valid & bus.P2_Ready);

    guess_slot #(.NUM_W(NUM_W)) u_slot1 (
        .Clock(Clock), .Reset(Reset), .clear(slot_clear), .collect(collect),
        .valid(bus.P1_Valid), .num(bus.P1_Num), .forfeit_set(p1_forfeit_set),
        .ready(bus.P1_Ready), .full(p1_full), .forfeit(p1_forfeit), .guess(p1_guess)
    );

    guess_slot #(.NUM_W(NUM_W)) u_slot2 (
        .Clock(Clock), .Reset(Reset), .clear(slot_clear), .collect(collect),
        .valid(bus.P2_Valid), .num(bus.P2_Num), .forfeit_set(p2_forfeit_set),
        .ready(bus.P2_Ready), .full(p2_full), .forfeit(p2_forfeit), .guess(p2_guess)
    );

`ifdef GAME_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;

    // Cycles spent in COLLECT; any other state parks it at zero so every entry restarts it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)        to_cnt <= '0;
        else if (collect) to_cnt <= to_cnt + CNT_W'(1);
        else              to_cnt <= '0;
    end

    assign timeout = collect && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and per-state control, defaults first.
    always_comb begin
        next_state     = state;
        start_acc      = 1'b0;
        slot_clear     = 1'b0;
        p1_forfeit_set = 1'b0;
        p2_forfeit_set = 1'b0;
        cmp_num        = '0;
        cmp_valid      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.Start) begin
                    start_acc  = 1'b1;
                    slot_clear = 1'b1;
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (p1_fill && p2_fill) begin
                    next_state = CHECK1;
                end else if (timeout) begin
                    p1_forfeit_set = ~p1_fill;
                    p2_forfeit_set = ~p2_fill;
                    next_state     = CHECK1;
                end
            end
            CHECK1: begin
                cmp_num    = p1_guess;
                cmp_valid  = ~p1_forfeit;
                next_state = CHECK2;
            end
            CHECK2: begin
                cmp_num    = p2_guess;
                cmp_valid  = ~p2_forfeit;
                next_state = DECIDE;
            end
            DECIDE: begin
                if (m1 || m2 || (round == LAST_ROUND)) begin
                    next_state = DONE;
                end else begin
                    slot_clear = 1'b1;
                    next_state = COLLECT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Game registers: target latch, round counter, match flags and outcome.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            target <= '0;
            round  <= '0;
            result <= RES_NONE;
            done   <= 1'b0;
            m1     <= 1'b0;
            m2     <= 1'b0;
        end else if (start_acc) begin
            target <= bus.Target_Num;
            round  <= '0;
            result <= RES_NONE;
            done   <= 1'b0;
        end else begin
            if (state == CHECK1) m1 <= bus.Cmp_Match & ~p1_forfeit;
            if (state == CHECK2) m2 <= bus.Cmp_Match & ~p2_forfeit;
            if (state == DECIDE) begin
                if (m1 && m2) begin
                    result <= RES_DRAW;
                    done   <= 1'b1;
                end else if (m1) begin
                    result <= RES_P1;
                    done   <= 1'b1;
                end else if (m2) begin
                    result <= RES_P2;
                    done   <= 1'b1;
                end else if (round == LAST_ROUND) begin
                    result <= RES_NONE;
                    done   <= 1'b1;
                end else begin
                    round  <= round + ROUND_W'(1);
                end
            end
        end
    end

    assign bus.Cmp_Target = target;
    assign bus.Cmp_Num    = cmp_num;
    assign bus.Cmp_Valid  = cmp_valid;
    assign bus.Result     = result;
    assign bus.Done       = done;
    assign bus.Round      = round;
    assign bus.State      = state;

endmodule
